// File: rtl/n2t_pkg.sv
// Shared constants and the one-bit demux selector cell for the n2t memory tiles.
// Storage tiles import this package so word width and tile geometry stay in one place.
package n2t_pkg;

    localparam int N2T_WORD_W      = 16;
    localparam int N2T_RAM8_DEPTH  = 8;
    localparam int N2T_RAM8_ADDR_W = 3;

    // Routes in to bit[sel]; the other output is 0.
    function automatic logic [1:0] n2t_dmux(input logic in, input logic sel);
        n2t_dmux = {in & sel, in & ~sel};
    endfunction

endpackage

// File: rtl/n2t_register16.sv
// Load-enabled word register with asynchronous active-low clear; out is the stored state.
module n2t_register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] state_reg;

    // in is only observed when load is high, so an unknown in cannot leak into the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
        end else if (load) begin
            state_reg <= in;
        end
    end

    assign out = state_reg;

endmodule

// File: rtl/n2t_ram8.sv
// Eight-word register bank: load is dmux-tree decoded to one word, out is mux-tree selected.
// Base storage tile for the larger RAM banks.
module n2t_ram8
    import n2t_pkg::*;
#(
    parameter int WIDTH  = N2T_WORD_W,
    parameter int DEPTH  = N2T_RAM8_DEPTH,
    parameter int ADDR_W = N2T_RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    logic [1:0]       strobe_l1;
    logic [3:0]       strobe_l2;
    logic [DEPTH-1:0] strobe;

    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] sel_l2 [4];
    logic [WIDTH-1:0] sel_l1 [2];

    // Load demux tree, MSB first: leaf index equals the address value.
    assign strobe_l1 = n2t_dmux(load, address[ADDR_W-1]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dmux_l2
            assign strobe_l2[2*gi +: 2] = n2t_dmux(strobe_l1[gi], address[ADDR_W-2]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_dmux_l3
            assign strobe[2*gi +: 2] = n2t_dmux(strobe_l2[gi], address[ADDR_W-3]);
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            n2t_register16 #(
                .WIDTH(WIDTH)
            ) u_word (
                .clk  (clk),
                .rst_n(rst_n),
                .in   (in),
                .load (strobe[gi]),
                .out  (word_q[gi])
            );
        end

        // Read mux tree, LSB first, mirroring the demux tree.
        for (gi = 0; gi < 4; gi++) begin : g_mux_l2
            assign sel_l2[gi] = address[ADDR_W-3] ? word_q[2*gi+1] : word_q[2*gi];
        end

        for (gi = 0; gi < 2; gi++) begin : g_mux_l1
            assign sel_l1[gi] = address[ADDR_W-2] ? sel_l2[2*gi+1] : sel_l2[2*gi];
        end
    endgenerate

    assign out = address[ADDR_W-1] ? sel_l1[1] : sel_l1[0];

endmodule

// File: tb/tb_n2t_ram8.sv
// Scoreboard bench for n2t_ram8: the driver queues expected reads, a monitor compares them.
module tb_n2t_ram8;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    int tests_run;
    int tests_failed;

    string       name_q[$];
    logic [15:0] exp_q[$];
    event        check_ev;

    n2t_ram8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .load   (load),
        .address(address),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every check event presents one DUT read to compare with the queue head.
    initial begin
        string       nm;
        logic [15:0] exp;
        forever begin
            @(check_ev);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_empty: out=%h with no expected value queued", out);
            end else begin
                nm  = name_q.pop_front();
                exp = exp_q.pop_front();
                if (out !== exp) begin
                    tests_failed++;
                    $display("FAIL %s: out=%h expected %h", nm, out, exp);
                end else begin
                    $display("[TB] ok   %s: out=%h", nm, out);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
        address = a;
        name_q.push_back(nm);
        exp_q.push_back(exp);
        #1;
        -> check_ev;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        $display("[TB] write addr=%0d data=%h", a, d);
    endtask

    initial begin
        logic [15:0] fill;
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        in      = '0;
        load    = 1'b0;
        address = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state_a0", 3'd0, 16'h0000);

        // Arbitrary writes, then a mid-cycle reset clears everything asynchronously.
        wr(3'd1, 16'h1234);
        wr(3'd6, 16'h5678);
        chk("pre_reset_a1", 3'd1, 16'h1234);
        chk("pre_reset_a6", 3'd6, 16'h5678);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int a = 0; a < 8; a++) chk($sformatf("async_reset_a%0d", a), 3'(a), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill pattern 0x1111*(k+1).
        for (int k = 0; k < 8; k++) begin
            fill = 16'(16'h1111 * (k + 1));
            wr(3'(k), fill);
        end
        chk("fill_a0", 3'd0, 16'h1111);
        chk("fill_a1", 3'd1, 16'h2222);
        chk("fill_a2", 3'd2, 16'h3333);
        chk("fill_a3", 3'd3, 16'h4444);
        chk("fill_a4", 3'd4, 16'h5555);
        chk("fill_a5", 3'd5, 16'h6666);
        chk("fill_a6", 3'd6, 16'h7777);
        chk("fill_a7", 3'd7, 16'h8888);

        // Read-during-write: old value before the edge, new value after it.
        @(negedge clk);
        address = 3'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        chk("rdw_before_edge", 3'd3, 16'h4444);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        chk("rdw_after_edge", 3'd3, 16'hBEEF);
        chk("rdw_neighbour_a2", 3'd2, 16'h3333);
        chk("rdw_neighbour_a4", 3'd4, 16'h5555);

        // Load gating: in=0xFFFF on every address with load low.
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            address = 3'(a);
            in      = 16'hFFFF;
            load    = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("gate_a0", 3'd0, 16'h1111);
        chk("gate_a3", 3'd3, 16'hBEEF);
        chk("gate_a5", 3'd5, 16'h6666);
        chk("gate_a7", 3'd7, 16'h8888);

        // Back-to-back writes to the same address on consecutive edges.
        @(negedge clk);
        address = 3'd2;
        in      = 16'h0A0A;
        load    = 1'b1;
        @(negedge clk);
        in = 16'h0B0B;
        @(negedge clk);
        load = 1'b0;
        chk("b2b_last_wins", 3'd2, 16'h0B0B);

        // Reset-vs-write race: reset low across the edge with load=1.
        @(negedge clk);
        address = 3'd5;
        in      = 16'hA5A5;
        load    = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("race_a5", 3'd5, 16'h0000);
        chk("race_a4", 3'd4, 16'h0000);

        // Extremes: addresses 7 and 0, no aliasing into neighbours.
        wr(3'd7, 16'h8001);
        wr(3'd0, 16'h7FFE);
        chk("extreme_a7", 3'd7, 16'h8001);
        chk("extreme_a0", 3'd0, 16'h7FFE);
        chk("extreme_a6", 3'd6, 16'h0000);
        chk("extreme_a1", 3'd1, 16'h0000);

        #5;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
